// File: rtl/dac_sched_pkg.sv
// Shared types, frame layout and helpers for the dual-channel DAC SPI scheduler.
package dac_sched_pkg;

  localparam int FRAME_W = 16;
  localparam int CNT_W   = 16;

  localparam int BIT_CH   = 15;
  localparam int BIT_BUF  = 14;
  localparam int BIT_GA   = 13;
  localparam int BIT_SHDN = 12;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_GAP,
    S_LDAC
  } sched_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_CS_SETUP,
    TX_SHIFT,
    TX_CS_HOLD
  } tx_state_t;

  // Assemble one DAC command frame; the DAC is never put in shutdown.
  function automatic logic [FRAME_W-1:0] build_frame(input logic ch,
                                                     input logic buf_en,
                                                     input logic ga_n,
                                                     input logic [11:0] word);
    logic [FRAME_W-1:0] f;
    f           = '0;
    f[BIT_CH]   = ch;
    f[BIT_BUF]  = buf_en;
    f[BIT_GA]   = ga_n;
    f[BIT_SHDN] = 1'b1;
    f[11:0]     = word;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_scheduler_tx.sv
// Shifts one 16-bit frame out in SPI mode 0: CS setup, 16 SCLK periods, CS hold.
module spi_frame_tx
  import dac_sched_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               done,
  output logic               cs_n,
  output logic               sclk,
  output logic               mosi
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCLK_DIV - 1);

  tx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         bit_cnt, bit_nxt;
  logic [FRAME_W-1:0] shreg, sh_nxt;
  logic               cs_nxt, sclk_nxt, mosi_nxt;
  logic               div_end;

  // State and registered SPI pins; reset leaves the bus idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      cs_n    <= cs_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
    end
  end

  // Next-state logic; mosi only moves on the edge where sclk falls, so it is stable at every rising edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    cs_nxt    = cs_n;
    sclk_nxt  = sclk;
    mosi_nxt  = mosi;
    done      = 1'b0;
    div_end   = (cnt == DIV_LAST);
    case (state)
      TX_IDLE: begin
        if (start) begin
          state_nxt = TX_CS_SETUP;
          cs_nxt    = 1'b0;
          sh_nxt    = frame;
          mosi_nxt  = frame[FRAME_W-1];
          cnt_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      TX_CS_SETUP: begin
        if (div_end) begin
          state_nxt = TX_SHIFT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_SHIFT: begin
        if (!div_end) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
          if (!sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            sclk_nxt = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_nxt = TX_CS_HOLD;
            end else begin
              bit_nxt  = bit_cnt + 4'd1;
              sh_nxt   = {shreg[FRAME_W-2:0], 1'b0};
              mosi_nxt = shreg[FRAME_W-2];
            end
          end
        end
      end
      TX_CS_HOLD: begin
        if (div_end) begin
          state_nxt = TX_IDLE;
          cs_nxt    = 1'b1;
          mosi_nxt  = 1'b0;
          cnt_nxt   = '0;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/dac_spi_scheduler.sv
// Per sampling tick: writes channel A then B to the DAC, separated by a CS gap, then strobes LDAC_n.
module dac_spi_scheduler
  import dac_sched_pkg::*;
#(
  parameter int   SCLK_DIV = 2,
  parameter int   CS_GAP   = 4,
  parameter int   LDAC_W   = 2,
  parameter logic CFG_BUF  = 1'b0,
  parameter logic CFG_GA_N = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        enable_a,
  input  logic        enable_b,
  input  logic [11:0] dac_a_word,
  input  logic [11:0] dac_b_word,
  input  logic        overrun_clr,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_W - 1);

  sched_state_t       state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [11:0]        shadow_b, shadow_b_nxt;
  logic               pend_b, pend_b_nxt;
  logic               busy_nxt, overrun_nxt, ldac_nxt;
  logic               tx_start, tx_done;
  logic [FRAME_W-1:0] tx_frame;

  // Channel A is loaded into the shifter straight from the inputs at acceptance; B waits in its shadow register.
  spi_frame_tx #(
    .SCLK_DIV (SCLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .frame (tx_frame),
    .done  (tx_done),
    .cs_n  (spi_cs_n),
    .sclk  (spi_sclk),
    .mosi  (spi_mosi)
  );

  // Scheduler state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shadow_b   <= '0;
      pend_b     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shadow_b   <= shadow_b_nxt;
      pend_b     <= pend_b_nxt;
      busy       <= busy_nxt;
      overrun    <= overrun_nxt;
      dac_ldac_n <= ldac_nxt;
    end
  end

  // Channel ordering, inter-frame gap, LDAC strobe and sticky overrun (a new overrun beats a clear).
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shadow_b_nxt = shadow_b;
    pend_b_nxt   = pend_b;
    busy_nxt     = busy;
    ldac_nxt     = dac_ldac_n;
    tx_start     = 1'b0;
    tx_frame     = build_frame(CH_B, CFG_BUF, CFG_GA_N, shadow_b);
    overrun_nxt  = overrun;
    if (overrun_clr) overrun_nxt = 1'b0;
    if (busy && sample_tick) overrun_nxt = 1'b1;
    case (state)
      S_IDLE: begin
        if (sample_tick && (enable_a || enable_b)) begin
          state_nxt    = S_FRAME;
          busy_nxt     = 1'b1;
          shadow_b_nxt = dac_b_word;
          pend_b_nxt   = enable_a && enable_b;
          tx_start     = 1'b1;
          tx_frame     = enable_a ? build_frame(CH_A, CFG_BUF, CFG_GA_N, dac_a_word)
                                  : build_frame(CH_B, CFG_BUF, CFG_GA_N, dac_b_word);
        end
      end
      S_FRAME: begin
        if (tx_done) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (pend_b) begin
            pend_b_nxt = 1'b0;
            tx_start   = 1'b1;
            state_nxt  = S_FRAME;
          end else begin
            ldac_nxt  = 1'b0;
            state_nxt = S_LDAC;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_LDAC: begin
        if (cnt == LDAC_LAST) begin
          cnt_nxt   = '0;
          ldac_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
